// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 key-schedule sequencer slice.
//   AES_NR     : last round index (10 for AES-128)
//   AES_KEY_W  : round-key width in bits
//   RK_LAST    : AES_NR as a 4-bit index, for compares against round/address fields
//   state_t    : sequencer states
//   rk_array_t : full set of round keys, index 0 = cipher key
package aes_pkg;

  localparam int unsigned AES_NR    = 10;
  localparam int unsigned AES_KEY_W = 128;
  localparam logic [3:0]  RK_LAST   = 4'(AES_NR);

  typedef logic [AES_KEY_W-1:0] key_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  typedef logic [0:AES_NR][AES_KEY_W-1:0] rk_array_t;

endpackage

// File: rtl/aes_key_sched_seq_if.sv
// Host-side bus of the AES-128 key-schedule sequencer.
//   start      : request expansion of key_in (master -> slave)
//   key_in     : cipher key, [127:96] = w0     (master -> slave)
//   rd_addr    : round-key read index 0..10    (master -> slave)
//   busy       : expansion in progress         (slave -> master)
//   done       : one-cycle pulse, key 10 stored (slave -> master)
//   keys_valid : all 11 round keys valid       (slave -> master)
//   rd_key     : registered read data          (slave -> master)
interface aes_key_sched_seq_if;
  import aes_pkg::*;

  logic       start;
  key_t       key_in;
  logic [3:0] rd_addr;
  logic       busy;
  logic       done;
  logic       keys_valid;
  key_t       rd_key;

  modport master (
    output start, key_in, rd_addr,
    input  busy, done, keys_valid, rd_key
  );

  modport slave (
    input  start, key_in, rd_addr,
    output busy, done, keys_valid, rd_key
  );

endinterface

// File: rtl/aes_round_key_ram.sv
// 11 x 128 round-key store: one write port, one registered read port.
//   clk, rst : clock, synchronous active-low reset
//   clr      : clear all slots (zeroize builds only); a same-edge write wins
//   we       : write enable, waddr 0..10, wdata
//   rd_addr  : read index; > 10 reads as 0
//   rd_key   : read data, one cycle after rd_addr (old value on same-slot write)
// Macro KEY_SCHED_ZEROIZE_EN: when defined the store is cleared on reset and
// on clr; otherwise the store has no reset.
module aes_round_key_ram
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       we,
  input  logic [3:0] waddr,
  input  key_t       wdata,
  input  logic [3:0] rd_addr,
  output key_t       rd_key
);

  rk_array_t mem;

`ifdef KEY_SCHED_ZEROIZE_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem <= '0;
    end else begin
      if (clr) mem <= '0;
      if (we && (waddr <= RK_LAST)) mem[waddr] <= wdata;
    end
  end
`else
  // clr is only meaningful when zeroizing
  logic clr_unused;
  assign clr_unused = clr;

  always_ff @(posedge clk) begin
    if (we && (waddr <= RK_LAST)) mem[waddr] <= wdata;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_key <= '0;
    end else if (rd_addr <= RK_LAST) begin
      rd_key <= mem[rd_addr];
    end else begin
      rd_key <= '0;
    end
  end

endmodule

// File: rtl/aes_key_sched_seq.sv
// AES-128 key-expansion sequencer and round-key store.
// Latches the cipher key as round key 0, then drives an external single-round
// generator (gen_in_key/gen_round) and captures gen_out_key SBOX_LAT cycles
// after each request as round keys 1..10.
//   clk, rst    : clock, synchronous active-low reset
//   bus         : host interface (start/key_in/rd_addr in; busy/done/
//                 keys_valid/rd_key out)
//   gen_round   : round number to the generator (0 when idle)
//   gen_in_key  : previous round key to the generator
//   gen_out_key : next round key from the generator
// Parameters: SBOX_LAT (generator latency, 0 = combinational), NUM_ROUNDS (10).
// Macro KEY_SCHED_ZEROIZE_EN: clear the key store on reset and on every start.
module aes_key_sched_seq
  import aes_pkg::*;
#(
  parameter int unsigned SBOX_LAT   = 1,
  parameter int unsigned NUM_ROUNDS = AES_NR
) (
  input  logic                clk,
  input  logic                rst,
  aes_key_sched_seq_if.slave  bus,
  output logic [3:0]          gen_round,
  output key_t                gen_in_key,
  input  key_t                gen_out_key
);

  localparam logic [3:0] LAT  = 4'(SBOX_LAT);
  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  state_t     state;
  logic [3:0] rnd;
  logic [3:0] wait_cnt;
  logic       accept;
  logic       capture;

  // Reset wins over a coincident start, and over a capture.
  assign accept  = rst && (state == IDLE) && bus.start;
  assign capture = rst && (state == CALC) && (wait_cnt == LAT);

  // gen_in_key doubles as the current round key: it is always the most
  // recently stored key, so no separate copy is kept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      rnd            <= '0;
      wait_cnt       <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.keys_valid <= 1'b0;
      gen_round      <= '0;
      gen_in_key     <= '0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            rnd            <= 4'd1;
            wait_cnt       <= '0;
            bus.keys_valid <= 1'b0;
            bus.busy       <= 1'b1;
            gen_round      <= 4'd1;
            gen_in_key     <= bus.key_in;
            state          <= CALC;
          end
        end
        CALC: begin
          if (capture) begin
            wait_cnt   <= '0;
            gen_in_key <= gen_out_key;
            if (rnd == LAST) begin
              // drop gen_round here so round 10 is held no longer than the others
              gen_round <= '0;
              state     <= FINISH;
            end else begin
              rnd       <= rnd + 4'd1;
              gen_round <= rnd + 4'd1;
            end
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        FINISH: begin
          bus.done       <= 1'b1;
          bus.keys_valid <= 1'b1;
          bus.busy       <= 1'b0;
          gen_round      <= '0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  aes_round_key_ram u_ram (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .we      (accept || capture),
    .waddr   (accept ? 4'd0 : rnd),
    .wdata   (accept ? bus.key_in : gen_out_key),
    .rd_addr (bus.rd_addr),
    .rd_key  (bus.rd_key)
  );

endmodule

// File: tb/tb_aes_key_sched_seq.sv
// Self-checking bench for aes_key_sched_seq with a behavioural single-round
// AES-128 key generator attached. Reads and done pulses are checked by a
// monitor against expectation queues filled by the stimulus.
// Honours KEY_SCHED_ZEROIZE_EN for the zeroize-specific checks.
module tb_aes_key_sched_seq;
  import aes_pkg::*;

  localparam int unsigned L        = 1;
  localparam int unsigned DONE_REL = 10 * (L + 1) + 1;

  localparam key_t FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam key_t FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam key_t FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam key_t B_KEY    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam key_t B_R10    = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam key_t ALT_KEY  = 128'hffeeddccbbaa99887766554433221100;

  typedef struct {
    string nm;
    key_t  val;
  } rd_exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] gen_round;
  key_t       gen_in_key;
  key_t       gen_out_key;

  aes_key_sched_seq_if bus ();

  aes_key_sched_seq #(.SBOX_LAT(L), .NUM_ROUNDS(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .gen_round   (gen_round),
    .gen_in_key  (gen_in_key),
    .gen_out_key (gen_out_key)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;
  logic        rd_req   = 1'b0;
  logic        hs_en    = 1'b0;
  rd_exp_t     rdq[$];
  int unsigned doneq[$];

  // ---------------- reference generator ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s;
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x] = s;
    end
  end

  function automatic key_t next_rk(input key_t k, input logic [3:0] r);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  rc;
    {w0, w1, w2, w3} = k;
    t = {w3[23:0], w3[31:24]};
    t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    rc = 8'h01;
    for (int i = 1; i < int'(r); i++) rc = xt(rc);
    if (r == 0) rc = 8'h00;
    t[31:24] = t[31:24] ^ rc;
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  if (L == 0) begin : g_gen_comb
    always_comb gen_out_key = next_rk(gen_in_key, gen_round);
  end else begin : g_gen_reg
    always @(posedge clk) gen_out_key <= next_rk(gen_in_key, gen_round);
  end

  // ---------------- clock, cycle count, watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input key_t act, input key_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] addr, input key_t exp, input string nm);
    bus.rd_addr = addr;
    rd_req = 1'b1;
    rdq.push_back('{nm, exp});
    step();
    rd_req = 1'b0;
  endtask

  // Start an expansion and wait for done; optional ignored start pulses.
  task automatic run(input key_t key, input bit pulses);
    int unsigned s;
    bit          seen;
    bus.key_in = key;
    bus.start  = 1'b1;
    step();
    bus.start = 1'b0;
    s = cyc;
    doneq.push_back(s + DONE_REL);
    chk("busy_after_start", key_t'(bus.busy), 1);
    chk("keys_valid_after_start", key_t'(bus.keys_valid), 0);
    seen = 1'b0;
    for (int i = 1; i <= 60 && !seen; i++) begin
      bus.start = pulses && (i == 5 || i == 15);
      if (bus.start) bus.key_in = ALT_KEY;
`ifdef KEY_SCHED_ZEROIZE_EN
      rd_req = (i == 2);
      if (i == 2) begin
        bus.rd_addr = 4'd5;
        rdq.push_back('{"slot5_zeroized_before_round5", '0});
      end
`endif
      step();
      seen = bus.done;
    end
    bus.start = 1'b0;
    rd_req    = 1'b0;
    if (!seen) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("keys_valid_at_done", key_t'(bus.keys_valid), 1);
      chk("busy_at_done", key_t'(bus.busy), 0);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin : mon
    logic    req_d;
    rd_exp_t e;
    forever begin
      @(posedge clk);
      req_d = rd_req;
      #1;
      if (req_d) begin
        if (rdq.size() == 0) begin
          chk("rd_unexpected", 1, 0);
        end else begin
          e = rdq.pop_front();
          chk(e.nm, bus.rd_key, e.val);
        end
      end
      if (bus.done === 1'b1) begin
        if (doneq.size() == 0) chk("done_unexpected", 1, 0);
        else chk("done_cycle", key_t'(cyc), key_t'(doneq.pop_front()));
      end
    end
  end

  // gen_round steps 1..10, each held L+1 cycles; round-2 input is round-1 key.
  initial begin : hs_mon
    logic [3:0]  prev;
    int unsigned run_len;
    prev = '0;
    run_len = 0;
    forever begin
      step();
      if (!hs_en) begin
        prev = '0;
        run_len = 0;
      end else if (gen_round == prev) begin
        run_len++;
      end else begin
        if (prev != 0) chk("gen_round_hold", key_t'(run_len), key_t'(L + 1));
        if (gen_round != 0) chk("gen_round_step", key_t'(gen_round), key_t'(prev + 4'd1));
        if (gen_round == 4'd2) chk("gen_in_key_round2", gen_in_key, FIPS_R1);
        prev = gen_round;
        run_len = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst         = 1'b0;
    bus.start   = 1'b0;
    bus.key_in  = '0;
    bus.rd_addr = '0;
    repeat (3) step();
    chk("reset_busy", key_t'(bus.busy), 0);
    chk("reset_done", key_t'(bus.done), 0);
    chk("reset_keys_valid", key_t'(bus.keys_valid), 0);
    chk("reset_gen_round", key_t'(gen_round), 0);
    chk("reset_gen_in_key", gen_in_key, '0);
    chk("reset_rd_key", bus.rd_key, '0);
    rst = 1'b1;
    step();

`ifdef KEY_SCHED_ZEROIZE_EN
    for (int a = 0; a <= 10; a++) rd(4'(a), '0, "zeroize_after_reset");
`endif

    // FIPS-197 key with ignored starts at relative cycles 5 and 15
    hs_en = 1'b1;
    run(FIPS_KEY, 1'b1);
    hs_en = 1'b0;
    rd(4'd1, FIPS_R1, "rk1_fips");
    rd(4'd10, FIPS_R10, "rk10_fips");
    rd(4'd0, FIPS_KEY, "rk0_fips");
    rd(4'd11, '0, "rd_addr11_zero");
    chk("keys_valid_held", key_t'(bus.keys_valid), 1);

    // reset at relative cycle 8, together with a start: reset wins
    bus.key_in = FIPS_KEY;
    bus.start  = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (7) step();
    chk("busy_mid_run", key_t'(bus.busy), 1);
    rst       = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("abort_busy", key_t'(bus.busy), 0);
    chk("abort_keys_valid", key_t'(bus.keys_valid), 0);
    chk("abort_gen_round", key_t'(gen_round), 0);
    rst = 1'b1;
    step();
    chk("abort_stays_idle", key_t'(bus.busy), 0);

    // new key after abort, then back-to-back expansions
    run(B_KEY, 1'b0);
    rd(4'd10, B_R10, "rk10_b");
    rd(4'd0, B_KEY, "rk0_b");
    run(FIPS_KEY, 1'b0);
    run(B_KEY, 1'b0);
    rd(4'd10, B_R10, "rk10_b_back_to_back");
    rd(4'd1, next_rk(B_KEY, 4'd1) ^ '0, "rk1_b_back_to_back");

    repeat (3) step();
    chk("rd_queue_drained", key_t'(rdq.size()), 0);
    chk("done_queue_drained", key_t'(doneq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
